// File: rtl/hint_bit_pack_if.sv
// Handshake and byte-stream bundle for the ML-DSA-87 hint packer.
// Optional macro HINT_PACK_WEIGHT_OUT_EN adds the weight_o hint-weight output.
interface hint_bit_pack_if;
    logic       start_i;
    logic       h_valid_i;
    logic       h_ready_o;
    logic       h_bit_i;
    logic       byte_valid_o;
    logic       byte_ready_i;
    logic [7:0] byte_o;
    logic       busy_o;
    logic       done_o;
    logic       overflow_o;
`ifdef HINT_PACK_WEIGHT_OUT_EN
    logic [11:0] weight_o;

    modport master (
        output start_i, h_valid_i, h_bit_i, byte_ready_i,
        input  h_ready_o, byte_valid_o, byte_o, busy_o, done_o, overflow_o, weight_o
    );
    modport slave (
        input  start_i, h_valid_i, h_bit_i, byte_ready_i,
        output h_ready_o, byte_valid_o, byte_o, busy_o, done_o, overflow_o, weight_o
    );
`else
    modport master (
        output start_i, h_valid_i, h_bit_i, byte_ready_i,
        input  h_ready_o, byte_valid_o, byte_o, busy_o, done_o, overflow_o
    );
    modport slave (
        input  start_i, h_valid_i, h_bit_i, byte_ready_i,
        output h_ready_o, byte_valid_o, byte_o, busy_o, done_o, overflow_o
    );
`endif
endinterface

// File: rtl/hint_bit_pack.sv
// Streaming HintBitPack: packs K x N hint bits into the OMEGA+K byte h-field of an ML-DSA-87 signature.
// Optional macro HINT_PACK_WEIGHT_OUT_EN adds weight_o, the total count of accepted one-bits.
module hint_bit_pack #(
    parameter int K     = 8,
    parameter int OMEGA = 75,
    parameter int N     = 256
) (
    input logic         clk,
    input logic         rst_n,
    hint_bit_pack_if.slave bus
);

    localparam int         BYTES     = OMEGA + K;
    localparam logic [6:0] OMEGA_W   = 7'(OMEGA);
    localparam logic [6:0] LAST_W    = 7'(BYTES - 1);
    localparam logic [2:0] POLY_LAST = 3'(K - 1);
    localparam logic [7:0] COEF_LAST = 8'(N - 1);

    typedef enum logic [1:0] {IDLE, ABSORB, EMIT, DONE} state_t;

    state_t     state;
    state_t     next_state;

    logic [7:0] hint_buf [BYTES];
    logic [6:0] cnt;
    logic [2:0] poly;
    logic [7:0] coef;
    logic [6:0] out_idx;
    logic       overflow;

    logic       accept;
    logic       hit;
    logic       room;
    logic       poly_end;
    logic       byte_take;
    logic [6:0] cnt_next;

    logic       h_ready;
    logic       byte_valid;
    logic       busy;
    logic       done;
    logic [7:0] byte_data;

    assign accept    = (state == ABSORB) && bus.h_valid_i;
    assign hit       = accept && bus.h_bit_i;
    assign room      = (cnt < OMEGA_W);
    assign poly_end  = accept && (coef == COEF_LAST);
    assign byte_take = (state == EMIT) && bus.byte_ready_i;
    assign cnt_next  = cnt + {6'd0, hit && room};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        h_ready    = 1'b0;
        byte_valid = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.start_i) next_state = ABSORB;
            end
            ABSORB: begin
                h_ready = 1'b1;
                if (poly_end && (poly == POLY_LAST)) next_state = EMIT;
            end
            EMIT: begin
                byte_valid = 1'b1;
                if (bus.byte_ready_i && (out_idx == LAST_W)) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Unfilled index slots read as zero even though the buffer is also cleared at start.
    always_comb begin
        byte_data = 8'd0;
        if (state == EMIT) begin
            if ((out_idx < OMEGA_W) && (out_idx >= cnt)) begin
                byte_data = 8'd0;
            end else begin
                byte_data = hint_buf[out_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BYTES; i++) hint_buf[i] <= 8'd0;
            cnt      <= 7'd0;
            poly     <= 3'd0;
            coef     <= 8'd0;
            out_idx  <= 7'd0;
            overflow <= 1'b0;
        end else begin
            if ((state == IDLE) && bus.start_i) begin
                for (int i = 0; i < BYTES; i++) hint_buf[i] <= 8'd0;
                cnt      <= 7'd0;
                poly     <= 3'd0;
                coef     <= 8'd0;
                out_idx  <= 7'd0;
                overflow <= 1'b0;
            end
            if (accept) begin
                coef <= coef + 8'd1;
                cnt  <= cnt_next;
                if (hit && room) hint_buf[cnt] <= coef;
                if (hit && !room) overflow <= 1'b1;
                // The count slot records the running total including this beat's one.
                if (poly_end) begin
                    hint_buf[OMEGA_W + {4'd0, poly}] <= {1'b0, cnt_next};
                    poly <= poly + 3'd1;
                end
            end
            if (byte_take) out_idx <= out_idx + 7'd1;
        end
    end

`ifdef HINT_PACK_WEIGHT_OUT_EN
    logic [11:0] weight;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            weight <= 12'd0;
        end else if ((state == IDLE) && bus.start_i) begin
            weight <= 12'd0;
        end else if (hit && (weight != 12'd2048)) begin
            weight <= weight + 12'd1;
        end
    end

    assign bus.weight_o = weight;
`endif

    assign bus.h_ready_o    = h_ready;
    assign bus.byte_valid_o = byte_valid;
    assign bus.byte_o       = byte_data;
    assign bus.busy_o       = busy;
    assign bus.done_o       = done;
    assign bus.overflow_o   = overflow;

endmodule
